// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: turns EX/MEM loads/stores into req/ack transactions on the
// data-memory port, stalls the pipeline while an access is outstanding, feeds MEM/WB.
module mem_stage_ctrl #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TO_W           = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        RegWrite_i,
    input  logic        MemtoReg_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] ALUdata_i,
    input  logic [31:0] MemWdata_i,
    input  logic [4:0]  RegWaddr_i,
    output logic        stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        RegWrite_o,
    output logic        MemtoReg_o,
    output logic [31:0] ALUdata_o,
    output logic [31:0] MemRdata_o,
    output logic [4:0]  RegWaddr_o,
    output logic        err_o
);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

    localparam logic            TO_EN   = (TIMEOUT_CYCLES > 0) ? 1'b1 : 1'b0;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t          r_state;
    logic [TO_W-1:0] r_cnt;
    logic            r_lat_regwrite;
    logic            r_lat_memtoreg;
    logic [4:0]      r_lat_waddr;

    logic w_acc;
    logic w_misal;
    logic w_timeout;

    assign w_acc     = MemRead_i | MemWrite_i;
    assign w_misal   = (ALUdata_i[1:0] != 2'b00);
    // An ack in the last allowed cycle wins over the abort.
    assign w_timeout = TO_EN && (r_state == ST_BUSY) && (r_cnt == TO_LAST) && !mem_ack_i;

    // Pipeline stall: accepted access in IDLE, or BUSY waiting with no ack and no abort.
    always_comb begin
        stall_o = 1'b0;
        if (rst_i) begin
            stall_o = 1'b0;
        end else if (r_state == ST_IDLE) begin
            stall_o = w_acc & ~w_misal;
        end else begin
            stall_o = ~mem_ack_i & ~w_timeout;
        end
    end

    // Access FSM, memory port registers and MEM/WB pipeline register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state        <= ST_IDLE;
            r_cnt          <= '0;
            r_lat_regwrite <= 1'b0;
            r_lat_memtoreg <= 1'b0;
            r_lat_waddr    <= 5'd0;
            mem_req_o      <= 1'b0;
            mem_we_o       <= 1'b0;
            mem_addr_o     <= 32'd0;
            mem_wdata_o    <= 32'd0;
            RegWrite_o     <= 1'b0;
            MemtoReg_o     <= 1'b0;
            ALUdata_o      <= 32'd0;
            MemRdata_o     <= 32'd0;
            RegWaddr_o     <= 5'd0;
            err_o          <= 1'b0;
        end else begin
            err_o <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_acc) begin
                        RegWrite_o <= RegWrite_i;
                        MemtoReg_o <= MemtoReg_i;
                        ALUdata_o  <= ALUdata_i;
                        RegWaddr_o <= RegWaddr_i;
                    end else begin
                        RegWrite_o <= 1'b0;
                        MemtoReg_o <= 1'b0;
                        if (w_misal) begin
                            err_o <= 1'b1;
                        end else begin
                            r_state        <= ST_BUSY;
                            r_cnt          <= '0;
                            mem_req_o      <= 1'b1;
                            mem_we_o       <= MemWrite_i;
                            mem_addr_o     <= {ALUdata_i[31:2], 2'b00};
                            mem_wdata_o    <= MemWdata_i;
                            r_lat_regwrite <= RegWrite_i;
                            r_lat_memtoreg <= MemtoReg_i;
                            r_lat_waddr    <= RegWaddr_i;
                        end
                    end
                end
                ST_BUSY: begin
                    if (mem_ack_i) begin
                        r_state    <= ST_IDLE;
                        mem_req_o  <= 1'b0;
                        RegWrite_o <= r_lat_regwrite;
                        MemtoReg_o <= r_lat_memtoreg;
                        ALUdata_o  <= mem_addr_o;
                        RegWaddr_o <= r_lat_waddr;
                        if (!mem_we_o) begin
                            MemRdata_o <= mem_rdata_i;
                        end
                    end else if (w_timeout) begin
                        r_state    <= ST_IDLE;
                        mem_req_o  <= 1'b0;
                        err_o      <= 1'b1;
                        RegWrite_o <= 1'b0;
                        MemtoReg_o <= 1'b0;
                    end else begin
                        r_cnt      <= r_cnt + {{(TO_W-1){1'b0}}, 1'b1};
                        RegWrite_o <= 1'b0;
                        MemtoReg_o <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    mem_req_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
